dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RV32I core: the target end of the data-memory port driven by the memory-access stage. It accepts one read or write request at a time on the `dmem` address/data/enable/mask signals and holds it for a programmable number of cycles. It then commits byte-masked writes or returns read data with a one-cycle valid pulse. It serves as the bench and FPGA data memory behind the hart, with latency set per build to exercise stall handling upstream.

## Interface
- `DEPTH_WORDS`, 1024: storage size in 32-bit words; power of two.
- `LATENCY`, 1: cycles from request acceptance to response; legal range 1..4.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `i_dmem_addr`  in  32  byte address from the memory-access stage.
- `i_dmem_wdata`  in  32  store data.
- `i_dmem_ren`  in  1  read request.
- `i_dmem_wen`  in  1  write request.
- `i_dmem_mask`  in  4  byte enables; bit n covers wdata[8n+7:8n].
- `o_dmem_ready`  out  1  responder idle and able to accept a request this cycle.
- `o_dmem_valid`  out  1  one-cycle response pulse for every accepted request, read or write.
- `o_dmem_rdata`  out  32  read data; meaningful only when valid follows a read.
- `o_dmem_err`  out  1  one-cycle pulse: ren and wen were both high at acceptance.

## Operation
- States:
  - IDLE: `o_dmem_ready`=1.
  - BUSY: down-counter running, ready=0.
- Acceptance occurs on a rising edge with state=IDLE and (ren|wen)=1.
  - On acceptance, latch addr, wdata, mask, and op.
  - Load the counter with LATENCY-1 and enter BUSY.
  - Requests presented while BUSY are ignored; they are neither queued nor flagged.
- Word index = addr[2+log2(DEPTH_WORDS)-1 : 2].
  - addr[1:0] is ignored.
  - Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4 bytes.
- Op resolution at acceptance:
  - wen=1 → write, regardless of ren.
  - ren=1 and wen=0 → read.
  - ren=1 and wen=1 → write, plus `o_dmem_err`=1 on the response cycle.
- BUSY transitions:
  - Counter decrements each edge.
  - On the edge where counter=0: perform the op, assert valid for the following cycle, and return to IDLE.
- Write commit:
  - Each byte n with mask[n]=1 is replaced by the latched wdata byte n.
  - Other bytes are unchanged.
  - mask=0000 changes nothing but still produces the valid pulse.
- Read:
  - `o_dmem_rdata` gets the full stored word; mask is ignored (sign/zero extension is the core's job).
  - rdata holds its value across write responses and idle cycles.
- Storage contents are not reset; uninitialised words read as X in simulation.

## Timing
- Reset values: ready=1, valid=0, err=0, rdata=32'h0, state=IDLE, counter=0.
- Acceptance at edge k → valid=1 and rdata updated during the cycle after edge k+LATENCY. A write is visible to any read accepted afterwards.
- ready=0 from edge k to edge k+LATENCY. ready=1 in the same cycle valid is high, so the next request can be accepted at edge k+LATENCY+1. Maximum throughput is one request per LATENCY+1 cycles.
- valid and err are exactly one cycle wide and never asserted while ready=0.
- Reset mid-operation:
  - The pending op is aborted and a pending write is not committed.
  - The state returns to IDLE with outputs at reset values on the next cycle.
  - Reset has priority over acceptance and completion on the same edge.
- Inputs need only be stable at the acceptance edge. Changes while BUSY have no effect.

## Test plan
- Full write then read (LATENCY=1):
  - Write addr 0x10, wdata 0xDEADBEEF, mask 1111.
  - Then read addr 0x10 → valid pulses on each response; rdata=0xDEADBEEF.
- Byte-masked write:
  - Preload 0xDEADBEEF at 0x10, then write wdata 0x00AA0000 with mask 0100.
  - Read → 0xDEAABEEF. A write with mask 0000 leaves the word unchanged and still returns valid.
- Latency and busy (LATENCY=3):
  - Accept a read at edge k → ready low for cycles k..k+2, valid during the cycle after edge k+3.
  - A second request held during BUSY is accepted only at edge k+4.
- Simultaneous ren and wen:
  - Request addr 0x20, wdata 0x12345678, mask 1111 → response has valid=1 and err=1.
  - A subsequent read of 0x20 → 0x12345678 with err=0.
- Aliasing (DEPTH_WORDS=1024):
  - Write 0xCAFEF00D at 0x1010, read 0x0010 → 0xCAFEF00D.
  - Addr 0x0013 also reads the same word.
- Reset mid-write (LATENCY=4):
  - 0x40 holds 0x11111111. Accept a write of 0x22222222 to 0x40, then assert rst for one cycle two edges later.
  - Expect no valid pulse and ready=1 after reset; reading 0x40 → 0x11111111.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory target for the RV32I memory-access stage: accepts one request at a time,
// holds it for LATENCY cycles, then commits a byte-masked write or returns the read word.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  CNT_LOAD = 2'(LATENCY - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t        r_state;
    logic [1:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [3:0]    r_mask;
    logic          r_is_write;
    logic          r_conflict;
    logic          r_ready;
    logic          r_valid;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_done;
    logic          w_unused_addr;

    assign w_accept      = (r_state == S_IDLE) && (i_dmem_ren || i_dmem_wen);
    assign w_done        = (r_state == S_BUSY) && (r_cnt == '0);
    // Upper address bits alias and byte offset is ignored.
    assign w_unused_addr = ^{i_dmem_addr[31:AW+2], i_dmem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_mask     <= '0;
            r_is_write <= 1'b0;
            r_conflict <= 1'b0;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx      <= i_dmem_addr[AW+1:2];
                        r_wdata    <= i_dmem_wdata;
                        r_mask     <= i_dmem_mask;
                        r_is_write <= i_dmem_wen;
                        r_conflict <= i_dmem_wen && i_dmem_ren;
                        r_cnt      <= CNT_LOAD;
                        r_ready    <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        if (!r_is_write) begin
                            r_rdata <= r_mem[r_idx];
                        end
                        r_valid <= 1'b1;
                        r_err   <= r_conflict;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Storage is not reset; a write pending at reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_done && r_is_write) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (r_mask[n]) begin
                    r_mem[r_idx][8*n +: 8] <= r_wdata[8*n +: 8];
                end
            end
        end
    end

    assign o_dmem_ready = r_ready;
    assign o_dmem_valid = r_valid;
    assign o_dmem_rdata = r_rdata;
    assign o_dmem_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected responses from a word-array
// model, a negedge monitor pops and compares on every valid pulse.
module tb_dmem_responder;

    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_dmem_addr;
    logic [31:0] i_dmem_wdata;
    logic        i_dmem_ren;
    logic        i_dmem_wen;
    logic [3:0]  i_dmem_mask;
    logic        o_dmem_ready;
    logic        o_dmem_valid;
    logic [31:0] o_dmem_rdata;
    logic        o_dmem_err;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_dmem_addr  (i_dmem_addr),
        .i_dmem_wdata (i_dmem_wdata),
        .i_dmem_ren   (i_dmem_ren),
        .i_dmem_wen   (i_dmem_wen),
        .i_dmem_mask  (i_dmem_mask),
        .o_dmem_ready (o_dmem_ready),
        .o_dmem_valid (o_dmem_valid),
        .o_dmem_rdata (o_dmem_rdata),
        .o_dmem_err   (o_dmem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rdata = '0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Issue one request, update the model at the acceptance edge, and check ready/valid timing.
    task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic re,
                         input logic we, input logic [3:0] m, input bit hold,
                         input bit use_exp, input logic [31:0] exp_rd);
        int unsigned n;
        exp_t        e;
        logic [9:0]  idx;
        n = 0;
        while (!o_dmem_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", {31'b0, o_dmem_ready}, 32'd1);
        i_dmem_addr  = a;
        i_dmem_wdata = w;
        i_dmem_ren   = re;
        i_dmem_wen   = we;
        i_dmem_mask  = m;
        @(posedge clk);
        idx = a[11:2];
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b]) model_mem[idx][8*b +: 8] = w[8*b +: 8];
            end
            e.rdata = last_rdata;
            e.err   = re;
        end else begin
            e.rdata    = use_exp ? exp_rd : model_mem[idx];
            last_rdata = e.rdata;
            e.err      = 1'b0;
        end
        sb.push_back(e);
        #1;
        if (!hold) begin
            i_dmem_ren   = 1'b0;
            i_dmem_wen   = 1'b0;
            i_dmem_addr  = $urandom();
            i_dmem_wdata = $urandom();
            i_dmem_mask  = 4'($urandom());
        end
        for (int i = 0; i < int'(LAT); i++) begin
            @(negedge clk);
            check("busy_ready_valid", {30'b0, o_dmem_ready, o_dmem_valid}, 32'd0);
        end
        @(negedge clk);
        check("resp_ready_valid", {30'b0, o_dmem_ready, o_dmem_valid}, 32'd3);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o_dmem_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=1 expected no response at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", o_dmem_rdata, e.rdata);
                check("resp_err", {31'b0, o_dmem_err}, {31'b0, e.err});
            end
        end else if (o_dmem_err) begin
            checks++;
            errors++;
            $display("FAIL err_without_valid: got err=1 expected 0 at %0t", $time);
        end
    end

    initial begin
        int unsigned n;
        logic [31:0] a;
        logic [9:0]  idx;
        int unsigned op;
        rst          = 1'b1;
        i_dmem_addr  = '0;
        i_dmem_wdata = '0;
        i_dmem_ren   = 1'b0;
        i_dmem_wen   = 1'b0;
        i_dmem_mask  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'b0, o_dmem_ready}, 32'd1);
        check("reset_valid", {31'b0, o_dmem_valid}, 32'd0);
        check("reset_err", {31'b0, o_dmem_err}, 32'd0);
        check("reset_rdata", o_dmem_rdata, 32'h0);

        for (int i = 0; i < 32; i++) begin
            issue(32'(i) << 2, $urandom(), 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, '0);
        end

        issue(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, '0);
        issue(32'h10, 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 32'hDEADBEEF);
        issue(32'h10, 32'h00AA0000, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, '0);
        issue(32'h10, 32'h0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 32'hDEAABEEF);
        issue(32'h10, 32'h55555555, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, '0);
        issue(32'h10, 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 32'hDEAABEEF);

        issue(32'h20, 32'h12345678, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, '0);
        issue(32'h20, 32'h0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 32'h12345678);

        issue(32'h1010, 32'hCAFEF00D, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, '0);
        issue(32'h0010, 32'h0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 32'hCAFEF00D);
        issue(32'h0013, 32'h0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 32'hCAFEF00D);

        // Held read: identical second request is taken only once ready returns.
        issue(32'h24, 32'h0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, '0);
        issue(32'h24, 32'h0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, '0);

        issue(32'h40, 32'h11111111, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, '0);
        i_dmem_addr  = 32'h40;
        i_dmem_wdata = 32'h22222222;
        i_dmem_mask  = 4'hF;
        i_dmem_wen   = 1'b1;
        i_dmem_ren   = 1'b0;
        @(posedge clk);
        #1 i_dmem_wen = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        last_rdata = '0;
        @(negedge clk);
        check("midreset_ready", {31'b0, o_dmem_ready}, 32'd1);
        check("midreset_valid", {31'b0, o_dmem_valid}, 32'd0);
        check("midreset_rdata", o_dmem_rdata, 32'h0);
        issue(32'h40, 32'h0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 32'h11111111);

        for (int t = 0; t < 200; t++) begin
            idx = 10'($urandom_range(0, 31));
            a   = ($urandom() & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            op  = $urandom_range(0, 2);
            issue(a, $urandom(), (op != 1), (op != 0), 4'($urandom()), 1'b0, 1'b0, '0);
        end

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
